// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, register-select encodings, condition codes, widths.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_BRANCH = 3'b001;

    localparam logic [1:0] REG_SEL_RD   = 2'b00;
    localparam logic [1:0] REG_SEL_RM   = 2'b01;
    localparam logic [1:0] REG_SEL_RN   = 2'b10;
    localparam logic [1:0] REG_SEL_NONE = 2'b11;

    typedef enum logic [2:0] {
        CondAl = 3'b000,
        CondEq = 3'b001,
        CondNe = 3'b010,
        CondLt = 3'b011,
        CondLe = 3'b100
    } cond_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: fields, immediates, register address, branch condition.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_ir,
    input  logic [1:0]        i_reg_sel,
    input  logic              i_z,
    input  logic              i_n,
    input  logic              i_v,
    output logic [2:0]        o_opcode,
    output logic [1:0]        o_op,
    output logic [1:0]        o_shift_op,
    output logic [2:0]        o_r_addr,
    output logic [DATA_W-1:0] o_sximm5,
    output logic [DATA_W-1:0] o_sximm8,
    output logic              o_cond_true
);

    logic [2:0] w_cond;
    logic       w_lt;

    assign o_opcode   = i_ir[15:13];
    assign o_op       = i_ir[12:11];
    assign o_shift_op = i_ir[4:3];
    assign o_sximm5   = {{(DATA_W-5){i_ir[4]}}, i_ir[4:0]};
    assign o_sximm8   = {{(DATA_W-8){i_ir[7]}}, i_ir[7:0]};
    assign w_cond     = i_ir[10:8];
    assign w_lt       = i_n ^ i_v;

    always_comb begin
        o_r_addr = 3'b000;
        unique case (i_reg_sel)
            REG_SEL_RD:   o_r_addr = i_ir[7:5];
            REG_SEL_RM:   o_r_addr = i_ir[2:0];
            REG_SEL_RN:   o_r_addr = i_ir[10:8];
            REG_SEL_NONE: o_r_addr = 3'b000;
            default:      o_r_addr = 3'b000;
        endcase
    end

    // Codes 101..111 are reserved and never taken.
    always_comb begin
        o_cond_true = 1'b0;
        case (w_cond)
            CondAl:  o_cond_true = 1'b1;
            CondEq:  o_cond_true = i_z;
            CondNe:  o_cond_true = ~i_z;
            CondLt:  o_cond_true = w_lt;
            CondLe:  o_cond_true = w_lt | i_z;
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, DAR and IR registers, next-PC adder and RAM address mux.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pc,
    input  logic              clear_pc,
    input  logic              pc_sel,
    input  logic              sel_addr,
    input  logic              load_addr,
    input  logic              load_ir,
    input  logic [1:0]        reg_sel,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              Z,
    input  logic              N,
    input  logic              V,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        shift_op,
    output logic [2:0]        r_addr,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              cond_true
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_dar;
    logic [DATA_W-1:0] r_ir;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_branch;
    logic              w_unused_dp;

    assign w_pc_plus1  = r_pc + ADDR_W'(1);
    // Branch target wraps modulo 2^ADDR_W; only the low offset bits matter.
    assign w_pc_branch = w_pc_plus1 + sximm8[ADDR_W-1:0];
    assign w_unused_dp = ^datapath_out[DATA_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_dar <= '0;
            r_ir  <= '0;
        end else begin
            if (clear_pc) begin
                r_pc <= '0;
            end else if (load_pc) begin
                r_pc <= pc_sel ? w_pc_branch : w_pc_plus1;
            end
            if (load_addr) begin
                r_dar <= datapath_out[ADDR_W-1:0];
            end
            if (load_ir) begin
                r_ir <= ram_rdata;
            end
        end
    end

    assign ram_addr = sel_addr ? r_pc : r_dar;
    assign pc_out   = r_pc;
    assign pc_plus1 = w_pc_plus1;

    instr_decoder #(
        .DATA_W (DATA_W)
    ) u_instr_decoder (
        .i_ir        (r_ir),
        .i_reg_sel   (reg_sel),
        .i_z         (Z),
        .i_n         (N),
        .i_v         (V),
        .o_opcode    (opcode),
        .o_op        (op),
        .o_shift_op  (shift_op),
        .o_r_addr    (r_addr),
        .o_sximm5    (sximm5),
        .o_sximm8    (sximm8),
        .o_cond_true (cond_true)
    );

endmodule
